// File: rtl/fwd_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: tracked-entry layout and select helpers.
package scoreboard_pkg;

    // Widest register index an entry can hold; narrower indices are zero-extended.
    localparam int unsigned REGW_MAX = 8;
    localparam int unsigned SEL_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic                wen;
        logic                is_load;
        logic [REGW_MAX-1:0] dest;
    } sb_entry_t;

    function automatic int unsigned sel_width(input int unsigned nstages);
        return (nstages < 2) ? 1 : $clog2(nstages);
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Issue/flush/forwarding bundle between the ID-stage hazard glue and fwd_scoreboard.
interface fwd_scoreboard_if #(
    parameter int unsigned NSTAGES = 3,
    parameter int unsigned NREAD   = 2,
    parameter int unsigned REGW    = 5,
    parameter int unsigned SELW    = scoreboard_pkg::sel_width(NSTAGES)
);
    logic                    advance;
    logic                    issue_valid;
    logic                    issue_wen;
    logic                    issue_is_load;
    logic [REGW-1:0]         issue_dest;
    logic [NREAD*REGW-1:0]   issue_rs;
    logic [NSTAGES-1:0]      flush_mask;
    logic                    flush_issue;
    logic                    stall;
    logic [NREAD*SELW-1:0]   fwd_sel;
    logic [31:0]             stall_cycles;

    modport master (
        output advance, issue_valid, issue_wen, issue_is_load, issue_dest, issue_rs,
        output flush_mask, flush_issue,
        input  stall, fwd_sel, stall_cycles
    );

    modport slave (
        input  advance, issue_valid, issue_wen, issue_is_load, issue_dest, issue_rs,
        input  flush_mask, flush_issue,
        output stall, fwd_sel, stall_cycles
    );

endinterface

// File: rtl/fwd_scoreboard_sb_match.sv
// sb_match: finds the youngest in-flight writer of one source register.
module sb_match
    import scoreboard_pkg::*;
#(
    parameter int unsigned NSRCH = 2,
    parameter int unsigned REGW  = 5,
    parameter int unsigned SELW  = 2
) (
    input  sb_entry_t [NSRCH-1:0] entries,
    input  logic [REGW-1:0]       rs,
    output logic                  hit,
    output logic [SELW-1:0]       idx,
    output logic                  is_load
);

    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        // Scan oldest to youngest so the youngest match is the one left standing.
        for (int i = int'(NSRCH) - 1; i >= 0; i--) begin
            if (entries[i].valid && entries[i].wen && (rs != '0) &&
                (entries[i].dest == REGW_MAX'(rs))) begin
                hit     = 1'b1;
                idx     = SELW'(i);
                is_load = entries[i].is_load;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// In-flight-write scoreboard producing registered bypass selects and the load-use interlock.
// Optional stall counter enabled by defining SCOREBOARD_PERF_EN.
module fwd_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned NSTAGES    = 3,
    parameter int unsigned NREAD      = 2,
    parameter int unsigned REGW       = 5,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned SELW       = sel_width(NSTAGES)
) (
    input logic              CLK,
    input logic              RST,
    fwd_scoreboard_if.slave  sb
);

    // The last stage writes the regfile early and is never searched, so it is not stored.
    localparam int unsigned NSRCH = NSTAGES - 1;

    sb_entry_t [NSRCH-1:0]   entries_q, entries_d;
    logic [NREAD*SELW-1:0]   fwd_sel_q, fwd_sel_d;
    logic [NREAD*SELW-1:0]   sel_calc;
    logic [NREAD-1:0]        port_stall;
    logic                    issue_ok;
    logic                    unused_flush;

    assign unused_flush = sb.flush_mask[NSTAGES-1];

    for (genvar k = 0; k < NREAD; k++) begin : g_port
        logic            hit;
        logic            hit_load;
        logic [SELW-1:0] idx;

        sb_match #(
            .NSRCH (NSRCH),
            .REGW  (REGW),
            .SELW  (SELW)
        ) u_match (
            .entries (entries_q),
            .rs      (sb.issue_rs[k*REGW +: REGW]),
            .hit     (hit),
            .idx     (idx),
            .is_load (hit_load)
        );

        // ID-time index i becomes EX-time select i+1 once this instruction advances.
        assign sel_calc[k*SELW +: SELW] = hit ? (idx + SELW'(1)) : SELW'(SEL_REGFILE);
        assign port_stall[k] = hit & hit_load & ((32'(idx) + 32'd1) < LOAD_STAGE);
    end

    assign sb.stall = sb.issue_valid & (|port_stall);
    assign issue_ok = sb.issue_valid & ~sb.stall & ~sb.flush_issue;

    always_comb begin
        entries_d = entries_q;
        fwd_sel_d = fwd_sel_q;
        if (sb.advance) begin
            for (int i = int'(NSRCH) - 1; i >= 1; i--) begin
                entries_d[i] = sb.flush_mask[i-1] ? '0 : entries_q[i-1];
            end
            entries_d[0] = '0;
            fwd_sel_d    = '0;
            if (issue_ok) begin
                entries_d[0].valid   = 1'b1;
                entries_d[0].wen     = sb.issue_wen;
                entries_d[0].is_load = sb.issue_is_load;
                entries_d[0].dest    = REGW_MAX'(sb.issue_dest);
                fwd_sel_d            = sel_calc;
            end
        end else begin
            // Frozen pipeline: squashes still land in place.
            for (int i = 0; i < int'(NSRCH); i++) begin
                if (sb.flush_mask[i]) begin
                    entries_d[i].valid = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            entries_q <= '0;
            fwd_sel_q <= '0;
        end else begin
            entries_q <= entries_d;
            fwd_sel_q <= fwd_sel_d;
        end
    end

    assign sb.fwd_sel = fwd_sel_q;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else if (sb.advance && sb.stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign sb.stall_cycles = stall_cnt_q;
`else
    assign sb.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Randomized and directed bench for fwd_scoreboard against an in-bench pipeline model.
module tb_fwd_scoreboard;

    localparam int N  = 3;
    localparam int LS = 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    fwd_scoreboard_if #(.NSTAGES(3), .NREAD(2), .REGW(5)) bus ();

    fwd_scoreboard #(
        .NSTAGES    (3),
        .NREAD      (2),
        .REGW       (5),
        .LOAD_STAGE (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .sb  (bus)
    );

    always #5 CLK = ~CLK;

    // Model: the in-flight instructions, index 0 youngest.
    logic       mv[N];
    logic       mw[N];
    logic       ml[N];
    logic [4:0] md[N];
    logic [3:0] mfs;
    logic [31:0] mcnt;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; mw[i] = 1'b0; ml[i] = 1'b0; md[i] = '0;
        end
        mfs  = '0;
        mcnt = '0;
    endtask

    // Youngest searchable producer per port; a load still too young means interlock.
    task automatic model_eval(output logic st, output logic [3:0] sel);
        logic [4:0] rs[2];
        int hit_at;
        rs[0] = bus.issue_rs[4:0];
        rs[1] = bus.issue_rs[9:5];
        st  = 1'b0;
        sel = '0;
        for (int k = 0; k < 2; k++) begin
            hit_at = -1;
            if (rs[k] != 0) begin
                for (int i = 0; i < N - 1 && hit_at < 0; i++) begin
                    if (mv[i] && mw[i] && md[i] == rs[k]) hit_at = i;
                end
            end
            if (hit_at >= 0) begin
                sel[k*2 +: 2] = 2'(hit_at + 1);
                if (ml[hit_at] && (hit_at + 1) < LS) st = 1'b1;
            end
        end
        st = st & bus.issue_valid;
    endtask

    task automatic compare();
        logic st;
        logic [3:0] sel;
        model_eval(st, sel);
        check("stall", bus.stall, st);
        check("fwd_sel", bus.fwd_sel, mfs);
        check("stall_cycles", bus.stall_cycles, mcnt);
    endtask

    // Apply the current inputs to the model, then let the clock edge happen.
    task automatic tick();
        logic st;
        logic [3:0] sel;
        logic ok;
        model_eval(st, sel);
        if (bus.advance) begin
            for (int i = N - 1; i >= 1; i--) begin
                mv[i] = mv[i-1] & ~bus.flush_mask[i-1];
                mw[i] = mw[i-1]; ml[i] = ml[i-1]; md[i] = md[i-1];
            end
            ok = bus.issue_valid & ~st & ~bus.flush_issue;
            mv[0] = ok; mw[0] = bus.issue_wen; ml[0] = bus.issue_is_load; md[0] = bus.issue_dest;
            mfs = ok ? sel : 4'd0;
`ifdef SCOREBOARD_PERF_EN
            if (st && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
`endif
        end else begin
            for (int i = 0; i < N; i++) if (bus.flush_mask[i]) mv[i] = 1'b0;
        end
        @(posedge CLK);
    endtask

    task automatic drive(input logic v, input logic w, input logic l, input logic [4:0] d,
                         input logic [4:0] r0, input logic [4:0] r1, input logic adv,
                         input logic [2:0] fm, input logic fi);
        @(negedge CLK);
        bus.issue_valid   = v;
        bus.issue_wen     = w;
        bus.issue_is_load = l;
        bus.issue_dest    = d;
        bus.issue_rs      = {r1, r0};
        bus.advance       = adv;
        bus.flush_mask    = fm;
        bus.flush_issue   = fi;
        #1;
    endtask

    task automatic step(input logic v, input logic w, input logic l, input logic [4:0] d,
                        input logic [4:0] r0, input logic [4:0] r1, input logic adv,
                        input logic [2:0] fm, input logic fi);
        drive(v, w, l, d, r0, r1, adv, fm, fi);
        compare();
        tick();
    endtask

    task automatic set_idle();
        bus.issue_valid = 1'b0; bus.issue_wen = 1'b0; bus.issue_is_load = 1'b0;
        bus.issue_dest = '0; bus.issue_rs = '0; bus.advance = 1'b0;
        bus.flush_mask = '0; bus.flush_issue = 1'b0;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2 RST = 1'b1;
        #1;
        model_clear();
        check("rst_fwd_sel", bus.fwd_sel, 0);
        check("rst_stall_cycles", bus.stall_cycles, 0);
        check("rst_stall", bus.stall, 0);
        set_idle();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        set_idle();
        model_clear();
        do_reset();

        // Dependent ALU ops.
        step(1, 1, 0, 3, 1, 2, 1, 0, 0);
        drive(1, 1, 0, 4, 3, 5, 1, 0, 0); compare(); check("dep_stall", bus.stall, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); compare(); check("dep_sel", bus.fwd_sel, 4'b0001);
        tick();

        // Distance 2 and 3.
        do_reset();
        step(1, 1, 0, 3, 1, 2, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 6, 3, 3, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); compare(); check("dist2_sel", bus.fwd_sel, 4'b1010);
        tick();
        do_reset();
        step(1, 1, 0, 3, 1, 2, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 6, 3, 3, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); compare(); check("dist3_sel", bus.fwd_sel, 4'b0000);
        tick();

        // Load-use interlock.
        do_reset();
        step(1, 1, 1, 2, 1, 0, 1, 0, 0);
        drive(1, 1, 0, 7, 2, 1, 1, 0, 0); compare(); check("lu_stall", bus.stall, 1); tick();
        drive(1, 1, 0, 7, 2, 1, 1, 0, 0); compare(); check("lu_stall_clr", bus.stall, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); compare(); check("lu_sel", bus.fwd_sel, 4'b0010);
`ifdef SCOREBOARD_PERF_EN
        check("lu_cnt", bus.stall_cycles, 1);
`else
        check("lu_cnt", bus.stall_cycles, 0);
`endif
        tick();

        // Freeze then resume.
        do_reset();
        step(1, 1, 0, 3, 1, 2, 1, 0, 0);
        step(1, 1, 0, 4, 3, 5, 1, 0, 0);
        for (int c = 0; c < 4; c++) begin
            drive(1, 1, 0, 6, 4, 3, 0, 0, 0); compare();
            check("frz_sel", bus.fwd_sel, 4'b0001); tick();
        end
        step(1, 1, 0, 6, 4, 3, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); compare(); check("frz_resume", bus.fwd_sel, 4'b1001);
        tick();

        // Flush of a load, r0 sources, duplicate destinations.
        do_reset();
        step(1, 1, 1, 2, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 3'b001, 0);
        drive(1, 1, 0, 8, 2, 2, 1, 0, 0); compare(); check("fl_stall", bus.stall, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); compare(); check("fl_sel", bus.fwd_sel, 4'b0000);
        tick();
        do_reset();
        step(1, 1, 0, 0, 1, 2, 1, 0, 0);
        step(1, 1, 1, 0, 1, 1, 1, 0, 0);
        drive(1, 1, 0, 9, 0, 0, 1, 0, 0); compare(); check("r0_stall", bus.stall, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); compare(); check("r0_sel", bus.fwd_sel, 4'b0000);
        tick();
        do_reset();
        step(1, 1, 0, 3, 1, 2, 1, 0, 0);
        step(1, 1, 0, 3, 1, 2, 1, 0, 0);
        step(1, 1, 0, 6, 3, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); compare(); check("young_sel", bus.fwd_sel, 4'b0001);
        tick();

        // Mid-operation asynchronous reset, then a cold sequence.
        do_reset();
        step(1, 1, 0, 5, 1, 2, 1, 0, 0);
        step(1, 1, 0, 4, 5, 0, 1, 0, 0);
        step(1, 1, 1, 3, 5, 0, 1, 0, 0);
        drive(1, 1, 0, 7, 3, 0, 1, 0, 0); compare();
        check("pre_rst_stall", bus.stall, 1);
        check("pre_rst_sel", bus.fwd_sel, 4'b0010);
        do_reset();
        step(1, 1, 0, 3, 1, 2, 1, 0, 0);
        step(1, 1, 0, 4, 3, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); compare(); check("cold_sel", bus.fwd_sel, 4'b0001);
        tick();

        // Randomized traffic over a small register set so hazards are frequent.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            logic [2:0] fm;
            for (int b = 0; b < 3; b++) fm[b] = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 4) != 0, fm, $urandom_range(0, 9) == 0);
            if (c == 1000) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
